// File: rtl/ftm_nmr_if.sv
// ftm_nmr_if: bundle of the signals exchanged between the redundant cores,
// the recovery firmware path and the ftm_nmr fault-tolerance manager.
//   master : drives the per-core retire tuples, enable, read requests, done
//   slave  : the manager; returns read data, core reset/recover controls and
//            fault status
// Core k occupies slice k of every packed per-core vector.
`timescale 1ns/1ps
interface ftm_nmr_if #(
  parameter int NUM_CORES  = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                             enable_i;
  logic [NUM_CORES-1:0]             valid_i;
  logic [NUM_CORES-1:0]             we_i;
  logic [NUM_CORES*ADDR_WIDTH-1:0]  addr_i;
  logic [NUM_CORES*DATA_WIDTH-1:0]  data_i;
  logic [NUM_CORES*DATA_WIDTH-1:0]  pc_i;
  logic                             rec_req_i;
  logic [ADDR_WIDTH:0]              rec_addr_i;
  logic                             rec_gnt_o;
  logic                             rec_rvalid_o;
  logic [DATA_WIDTH-1:0]            rec_rdata_o;
  logic                             done_i;
  logic                             reset_no;
  logic                             recover_o;
  logic                             recovering_o;
  logic                             error_o;
  logic                             fatal_o;
  logic [NUM_CORES-1:0]             faulty_core_o;
  logic [7:0]                       err_count_o;

  modport master (
    output enable_i, valid_i, we_i, addr_i, data_i, pc_i,
           rec_req_i, rec_addr_i, done_i,
    input  rec_gnt_o, rec_rvalid_o, rec_rdata_o, reset_no, recover_o,
           recovering_o, error_o, fatal_o, faulty_core_o, err_count_o
  );

  modport slave (
    input  enable_i, valid_i, we_i, addr_i, data_i, pc_i,
           rec_req_i, rec_addr_i, done_i,
    output rec_gnt_o, rec_rvalid_o, rec_rdata_o, reset_no, recover_o,
           recovering_o, error_o, fatal_o, faulty_core_o, err_count_o
  );
endinterface

// File: rtl/ftm_nmr.sv
// ftm_nmr: N-modular (DMR/TMR) fault-tolerance manager.
// Compares (DMR) or majority-votes (TMR) the per-core writeback tuples
// {valid, we, addr, data, pc}, commits clean results into a shadow register
// file plus a checkpoint PC, and sequences core reset / firmware recovery
// with a bounded retry count before declaring a fatal fault.
// Ports:
//   clk_i  : clock, all state on the rising edge
//   rst_ni : asynchronous active-low reset (control state only; shadow RF
//            and checkpoint keep their contents)
//   bus    : ftm_nmr_if slave modport (core tuples, read port, recovery
//            handshake, status outputs)
`timescale 1ns/1ps
module ftm_nmr #(
  parameter int NUM_CORES         = 2,
  parameter int ADDR_WIDTH        = 5,
  parameter int DATA_WIDTH        = 32,
  parameter int RESET_CYCLES      = 4,
  parameter int MAX_RETRIES       = 3,
  parameter int RESYNC_ON_CORRECT = 1
) (
  input logic   clk_i,
  input logic   rst_ni,
  ftm_nmr_if.slave bus
);

  localparam int TW = 2 + ADDR_WIDTH + 2 * DATA_WIDTH;
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic [1:0] {ST_RUN, ST_RESET, ST_RECOVER, ST_FATAL} state_t;

  state_t                 state;
  logic [RW-1:0]          retry;
  logic [CW-1:0]          rst_cnt;
  logic                   core_reset_n;
  logic                   recover_q;
  logic                   recovering_q;
  logic                   error_q;
  logic                   fatal_q;
  logic [NUM_CORES-1:0]   faulty_q;
  logic [7:0]             err_count;
  logic                   rvalid_q;
  logic [DATA_WIDTH-1:0]  rdata_q;

  logic [DATA_WIDTH-1:0]  rf [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0]  ckpt;

  logic [TW-1:0]          tuple [NUM_CORES];
  logic [TW-1:0]          voted;
  logic [NUM_CORES-1:0]   blame;
  logic                   multi;
  logic                   single;

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_tuple
    assign tuple[k] = {bus.valid_i[k], bus.we_i[k],
                       bus.addr_i[k*ADDR_WIDTH +: ADDR_WIDTH],
                       bus.data_i[k*DATA_WIDTH +: DATA_WIDTH],
                       bus.pc_i[k*DATA_WIDTH +: DATA_WIDTH]};
  end

  if (NUM_CORES == 3) begin : g_tmr
    // Bitwise majority; "multi" means no single core explains the vote,
    // which includes the case where all three cores disagree.
    assign voted = (tuple[0] & tuple[1]) | (tuple[0] & tuple[2]) | (tuple[1] & tuple[2]);
    for (genvar k = 0; k < 3; k++) begin : g_blame
      assign blame[k] = (tuple[k] != voted);
    end
    assign multi  = (blame[0] & blame[1]) | (blame[0] & blame[2]) | (blame[1] & blame[2]);
    assign single = (|blame) & ~multi;
  end else begin : g_dmr
    assign voted  = tuple[0];
    assign blame  = '0;
    assign multi  = (tuple[0] != tuple[1]);
    assign single = 1'b0;
  end

  logic [TW-1:0]          sel;
  logic                   sel_valid;
  logic                   sel_we;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [DATA_WIDTH-1:0]  sel_pc;
  logic                   in_run;
  logic                   check;
  logic                   uncorr;
  logic                   corr;
  logic                   fault;
  logic                   go_reset;
  logic                   ckpt_we;
  logic                   rf_we;
  logic                   clean;

  // Bypass (enable low) takes core 0's tuple as-is and never raises faults.
  assign sel       = bus.enable_i ? voted : tuple[0];
  assign sel_valid = sel[TW-1];
  assign sel_we    = sel[TW-2];
  assign sel_addr  = sel[TW-3 -: ADDR_WIDTH];
  assign sel_data  = sel[DATA_WIDTH +: DATA_WIDTH];
  assign sel_pc    = sel[DATA_WIDTH-1:0];

  assign in_run   = (state == ST_RUN);
  assign check    = bus.enable_i & in_run & (|bus.valid_i);
  assign uncorr   = check & multi;
  assign corr     = check & single;
  assign fault    = uncorr | corr;
  assign go_reset = uncorr | (corr & (RESYNC_ON_CORRECT != 0));
  assign ckpt_we  = in_run & sel_valid & ~uncorr;
  assign rf_we    = ckpt_we & sel_we;
  assign clean    = in_run & sel_valid & ~fault;

  assign bus.rec_gnt_o     = bus.rec_req_i;
  assign bus.rec_rvalid_o  = rvalid_q;
  assign bus.rec_rdata_o   = rdata_q;
  assign bus.reset_no      = core_reset_n;
  assign bus.recover_o     = recover_q;
  assign bus.recovering_o  = recovering_q;
  assign bus.error_o       = error_q;
  assign bus.fatal_o       = fatal_q;
  assign bus.faulty_core_o = faulty_q;
  assign bus.err_count_o   = err_count;

  // Control FSM and status; every output is registered here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= ST_RUN;
      retry        <= '0;
      rst_cnt      <= '0;
      core_reset_n <= 1'b0;
      recover_q    <= 1'b0;
      recovering_q <= 1'b0;
      error_q      <= 1'b0;
      fatal_q      <= 1'b0;
      faulty_q     <= '0;
      err_count    <= '0;
      rvalid_q     <= 1'b0;
    end else begin
      error_q  <= fault;
      faulty_q <= faulty_q | (blame & {NUM_CORES{check}});
      rvalid_q <= bus.rec_req_i;
      if (fault && err_count != 8'hFF) err_count <= err_count + 8'd1;
      case (state)
        ST_RUN: begin
          core_reset_n <= 1'b1;
          if (go_reset) begin
            core_reset_n <= 1'b0;
            if (retry == RW'(MAX_RETRIES)) begin
              state   <= ST_FATAL;
              fatal_q <= 1'b1;
            end else begin
              state        <= ST_RESET;
              recovering_q <= 1'b1;
              retry        <= retry + RW'(1);
              rst_cnt      <= '0;
            end
          end else if (clean) begin
            retry <= '0;
          end
        end
        ST_RESET: begin
          // Entered with reset_no already low, so the low phase spans
          // exactly RESET_CYCLES edges.
          if (rst_cnt == CW'(RESET_CYCLES - 1)) begin
            state        <= ST_RECOVER;
            core_reset_n <= 1'b1;
            recover_q    <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + CW'(1);
          end
        end
        ST_RECOVER: begin
          if (bus.done_i) begin
            state        <= ST_RUN;
            recover_q    <= 1'b0;
            recovering_q <= 1'b0;
          end
        end
        ST_FATAL: begin
          core_reset_n <= 1'b0;
          recover_q    <= 1'b0;
          recovering_q <= 1'b0;
          fatal_q      <= 1'b1;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Shadow state survives rst_ni; the read samples before the commit lands,
  // so a same-cycle read of a written address returns the old value.
  always_ff @(posedge clk_i) begin
    if (rf_we) rf[sel_addr] <= sel_data;
    if (ckpt_we) ckpt <= sel_pc;
    if (bus.rec_req_i) begin
      rdata_q <= bus.rec_addr_i[ADDR_WIDTH] ? ckpt : rf[bus.rec_addr_i[ADDR_WIDTH-1:0]];
    end
  end

endmodule

// File: tb/tb_ftm_nmr.sv
// tb_ftm_nmr: directed self-checking bench for ftm_nmr.
// Runs a DMR instance (RESYNC_ON_CORRECT=1) and a TMR instance
// (RESYNC_ON_CORRECT=0) side by side on a shared clock and reset.
`timescale 1ns/1ps
module tb_ftm_nmr;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ftm_nmr_if #(.NUM_CORES(2), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dmr_bus ();
  ftm_nmr_if #(.NUM_CORES(3), .ADDR_WIDTH(5), .DATA_WIDTH(32)) tmr_bus ();

  ftm_nmr #(.NUM_CORES(2), .ADDR_WIDTH(5), .DATA_WIDTH(32), .RESET_CYCLES(4),
            .MAX_RETRIES(3), .RESYNC_ON_CORRECT(1))
    u_dmr (.clk_i(clk), .rst_ni(rst_n), .bus(dmr_bus));

  ftm_nmr #(.NUM_CORES(3), .ADDR_WIDTH(5), .DATA_WIDTH(32), .RESET_CYCLES(4),
            .MAX_RETRIES(3), .RESYNC_ON_CORRECT(0))
    u_tmr (.clk_i(clk), .rst_ni(rst_n), .bus(tmr_bus));

  // One edge, then settle; all sampling happens 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dmr_drive(input logic v, input logic [4:0] a, input logic [31:0] d0,
                           input logic [31:0] d1, input logic [31:0] pc);
    dmr_bus.valid_i = {v, v};
    dmr_bus.we_i    = {v, v};
    dmr_bus.addr_i  = {a, a};
    dmr_bus.data_i  = {d1, d0};
    dmr_bus.pc_i    = {pc, pc};
  endtask

  task automatic tmr_drive(input logic v, input logic [4:0] a, input logic [31:0] d0,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] pc);
    tmr_bus.valid_i = {v, v, v};
    tmr_bus.we_i    = {v, v, v};
    tmr_bus.addr_i  = {a, a, a};
    tmr_bus.data_i  = {d2, d1, d0};
    tmr_bus.pc_i    = {pc, pc, pc};
  endtask

  task automatic test_reset();
    dmr_drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    tmr_drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    dmr_bus.enable_i = 1'b1; dmr_bus.rec_req_i = 1'b0; dmr_bus.rec_addr_i = '0; dmr_bus.done_i = 1'b0;
    tmr_bus.enable_i = 1'b1; tmr_bus.rec_req_i = 1'b0; tmr_bus.rec_addr_i = '0; tmr_bus.done_i = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    checks++; if (dmr_bus.reset_no !== 1'b0) begin errors++; $display("[TB] FAIL rst_reset_no: got %b expected 0", dmr_bus.reset_no); end
    checks++; if (dmr_bus.recover_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_recover: got %b expected 0", dmr_bus.recover_o); end
    checks++; if (dmr_bus.recovering_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_recovering: got %b expected 0", dmr_bus.recovering_o); end
    checks++; if (dmr_bus.error_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_error: got %b expected 0", dmr_bus.error_o); end
    checks++; if (dmr_bus.fatal_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_fatal: got %b expected 0", dmr_bus.fatal_o); end
    checks++; if (dmr_bus.err_count_o !== 8'd0) begin errors++; $display("[TB] FAIL rst_err_count: got %0d expected 0", dmr_bus.err_count_o); end
    checks++; if (dmr_bus.rec_rvalid_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_rvalid: got %b expected 0", dmr_bus.rec_rvalid_o); end
    checks++; if (tmr_bus.faulty_core_o !== 3'b000) begin errors++; $display("[TB] FAIL rst_tmr_faulty: got %b expected 000", tmr_bus.faulty_core_o); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    checks++; if (dmr_bus.reset_no !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_dmr: got %b expected 1", dmr_bus.reset_no); end
    checks++; if (tmr_bus.reset_no !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_tmr: got %b expected 1", tmr_bus.reset_no); end
  endtask

  task automatic test_dmr_commit();
    dmr_drive(1'b1, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h100);
    tick();
    checks++; if (dmr_bus.error_o !== 1'b0) begin errors++; $display("[TB] FAIL commit_error: got %b expected 0", dmr_bus.error_o); end
    dmr_drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    dmr_bus.rec_req_i = 1'b1; dmr_bus.rec_addr_i = 6'h05;
    #1;
    checks++; if (dmr_bus.rec_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL commit_gnt: got %b expected 1", dmr_bus.rec_gnt_o); end
    tick();
    checks++; if (dmr_bus.rec_rvalid_o !== 1'b1) begin errors++; $display("[TB] FAIL commit_rvalid: got %b expected 1", dmr_bus.rec_rvalid_o); end
    checks++; if (dmr_bus.rec_rdata_o !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL commit_r5: got %h expected deadbeef", dmr_bus.rec_rdata_o); end
    dmr_bus.rec_addr_i = 6'h20;
    tick();
    checks++; if (dmr_bus.rec_rdata_o !== 32'h100) begin errors++; $display("[TB] FAIL commit_ckpt: got %h expected 00000100", dmr_bus.rec_rdata_o); end
    checks++; if (dmr_bus.error_o !== 1'b0) begin errors++; $display("[TB] FAIL commit_error2: got %b expected 0", dmr_bus.error_o); end
    dmr_bus.rec_req_i = 1'b0;
    #1;
    checks++; if (dmr_bus.rec_gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL commit_gnt_low: got %b expected 0", dmr_bus.rec_gnt_o); end
    tick();
    checks++; if (dmr_bus.rec_rvalid_o !== 1'b0) begin errors++; $display("[TB] FAIL commit_rvalid_low: got %b expected 0", dmr_bus.rec_rvalid_o); end
  endtask

  task automatic test_same_cycle_read();
    dmr_drive(1'b1, 5'd5, 32'h12345678, 32'h12345678, 32'h104);
    dmr_bus.rec_req_i = 1'b1; dmr_bus.rec_addr_i = 6'h05;
    tick();
    checks++; if (dmr_bus.rec_rdata_o !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rw_same_old: got %h expected deadbeef", dmr_bus.rec_rdata_o); end
    dmr_drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    checks++; if (dmr_bus.rec_rdata_o !== 32'h12345678) begin errors++; $display("[TB] FAIL rw_same_new: got %h expected 12345678", dmr_bus.rec_rdata_o); end
    dmr_bus.rec_addr_i = 6'h20;
    tick();
    checks++; if (dmr_bus.rec_rdata_o !== 32'h104) begin errors++; $display("[TB] FAIL rw_same_ckpt: got %h expected 00000104", dmr_bus.rec_rdata_o); end
    dmr_bus.rec_req_i = 1'b0;
  endtask

  task automatic test_bypass();
    dmr_bus.enable_i = 1'b0;
    dmr_drive(1'b1, 5'd4, 32'h1, 32'h2, 32'h400);
    tick();
    checks++; if (dmr_bus.error_o !== 1'b0) begin errors++; $display("[TB] FAIL bypass_error: got %b expected 0", dmr_bus.error_o); end
    checks++; if (dmr_bus.reset_no !== 1'b1) begin errors++; $display("[TB] FAIL bypass_reset_no: got %b expected 1", dmr_bus.reset_no); end
    dmr_drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    dmr_bus.enable_i = 1'b1;
    dmr_bus.rec_req_i = 1'b1; dmr_bus.rec_addr_i = 6'h04;
    tick();
    checks++; if (dmr_bus.rec_rdata_o !== 32'h1) begin errors++; $display("[TB] FAIL bypass_r4: got %h expected 00000001", dmr_bus.rec_rdata_o); end
    dmr_bus.rec_addr_i = 6'h20;
    tick();
    checks++; if (dmr_bus.rec_rdata_o !== 32'h400) begin errors++; $display("[TB] FAIL bypass_ckpt: got %h expected 00000400", dmr_bus.rec_rdata_o); end
    dmr_bus.rec_req_i = 1'b0;
    checks++; if (dmr_bus.err_count_o !== 8'd0) begin errors++; $display("[TB] FAIL bypass_count: got %0d expected 0", dmr_bus.err_count_o); end
  endtask

  task automatic test_dmr_fault();
    dmr_drive(1'b1, 5'd3, 32'hAAAA, 32'hAAAA, 32'h108);
    tick();
    dmr_drive(1'b1, 5'd3, 32'h1, 32'h2, 32'h10C);
    tick();
    checks++; if (dmr_bus.error_o !== 1'b1) begin errors++; $display("[TB] FAIL dfault_error: got %b expected 1", dmr_bus.error_o); end
    checks++; if (dmr_bus.reset_no !== 1'b0) begin errors++; $display("[TB] FAIL dfault_reset_no: got %b expected 0", dmr_bus.reset_no); end
    checks++; if (dmr_bus.recovering_o !== 1'b1) begin errors++; $display("[TB] FAIL dfault_recovering: got %b expected 1", dmr_bus.recovering_o); end
    checks++; if (dmr_bus.err_count_o !== 8'd1) begin errors++; $display("[TB] FAIL dfault_count: got %0d expected 1", dmr_bus.err_count_o); end
    // A clean-looking write during RESET must be ignored.
    dmr_drive(1'b1, 5'd3, 32'h5555, 32'h5555, 32'h500);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (dmr_bus.reset_no !== 1'b0) begin errors++; $display("[TB] FAIL dfault_hold_%0d: got %b expected 0", i, dmr_bus.reset_no); end
      checks++; if (dmr_bus.error_o !== 1'b0) begin errors++; $display("[TB] FAIL dfault_pulse_%0d: got %b expected 0", i, dmr_bus.error_o); end
    end
    tick();
    checks++; if (dmr_bus.reset_no !== 1'b1) begin errors++; $display("[TB] FAIL dfault_release: got %b expected 1", dmr_bus.reset_no); end
    checks++; if (dmr_bus.recover_o !== 1'b1) begin errors++; $display("[TB] FAIL dfault_recover: got %b expected 1", dmr_bus.recover_o); end
    dmr_drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick(); tick();
    checks++; if (dmr_bus.recover_o !== 1'b1) begin errors++; $display("[TB] FAIL dfault_recover_hold: got %b expected 1", dmr_bus.recover_o); end
    dmr_bus.done_i = 1'b1;
    tick();
    dmr_bus.done_i = 1'b0;
    checks++; if (dmr_bus.recover_o !== 1'b0) begin errors++; $display("[TB] FAIL dfault_done: got %b expected 0", dmr_bus.recover_o); end
    checks++; if (dmr_bus.recovering_o !== 1'b0) begin errors++; $display("[TB] FAIL dfault_run: got %b expected 0", dmr_bus.recovering_o); end
    dmr_bus.rec_req_i = 1'b1; dmr_bus.rec_addr_i = 6'h03;
    tick();
    checks++; if (dmr_bus.rec_rdata_o !== 32'hAAAA) begin errors++; $display("[TB] FAIL dfault_r3: got %h expected 0000aaaa", dmr_bus.rec_rdata_o); end
    dmr_bus.rec_addr_i = 6'h20;
    tick();
    checks++; if (dmr_bus.rec_rdata_o !== 32'h108) begin errors++; $display("[TB] FAIL dfault_ckpt: got %h expected 00000108", dmr_bus.rec_rdata_o); end
    dmr_bus.rec_req_i = 1'b0;
  endtask

  task automatic test_tmr_correct();
    tmr_drive(1'b1, 5'd7, 32'h0F, 32'hFF, 32'h0F, 32'h200);
    tick();
    checks++; if (tmr_bus.error_o !== 1'b1) begin errors++; $display("[TB] FAIL tcorr_error: got %b expected 1", tmr_bus.error_o); end
    checks++; if (tmr_bus.faulty_core_o !== 3'b010) begin errors++; $display("[TB] FAIL tcorr_faulty: got %b expected 010", tmr_bus.faulty_core_o); end
    checks++; if (tmr_bus.err_count_o !== 8'd1) begin errors++; $display("[TB] FAIL tcorr_count: got %0d expected 1", tmr_bus.err_count_o); end
    checks++; if (tmr_bus.reset_no !== 1'b1) begin errors++; $display("[TB] FAIL tcorr_reset_no: got %b expected 1", tmr_bus.reset_no); end
    tmr_drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    tmr_bus.rec_req_i = 1'b1; tmr_bus.rec_addr_i = 6'h07;
    tick();
    checks++; if (tmr_bus.reset_no !== 1'b1) begin errors++; $display("[TB] FAIL tcorr_reset_no2: got %b expected 1", tmr_bus.reset_no); end
    checks++; if (tmr_bus.error_o !== 1'b0) begin errors++; $display("[TB] FAIL tcorr_pulse: got %b expected 0", tmr_bus.error_o); end
    checks++; if (tmr_bus.rec_rdata_o !== 32'h0F) begin errors++; $display("[TB] FAIL tcorr_r7: got %h expected 0000000f", tmr_bus.rec_rdata_o); end
    tmr_bus.rec_addr_i = 6'h20;
    tick();
    checks++; if (tmr_bus.rec_rdata_o !== 32'h200) begin errors++; $display("[TB] FAIL tcorr_ckpt: got %h expected 00000200", tmr_bus.rec_rdata_o); end
    tmr_bus.rec_req_i = 1'b0;
  endtask

  task automatic test_tmr_uncorrectable();
    tmr_drive(1'b1, 5'd9, 32'h77, 32'h77, 32'h77, 32'h204);
    tick();
    // 1/2/4 vote bitwise to 0, which matches none of the cores.
    tmr_drive(1'b1, 5'd9, 32'h1, 32'h2, 32'h4, 32'h208);
    tick();
    checks++; if (tmr_bus.faulty_core_o !== 3'b111) begin errors++; $display("[TB] FAIL tunc_faulty: got %b expected 111", tmr_bus.faulty_core_o); end
    checks++; if (tmr_bus.error_o !== 1'b1) begin errors++; $display("[TB] FAIL tunc_error: got %b expected 1", tmr_bus.error_o); end
    checks++; if (tmr_bus.err_count_o !== 8'd2) begin errors++; $display("[TB] FAIL tunc_count: got %0d expected 2", tmr_bus.err_count_o); end
    checks++; if (tmr_bus.reset_no !== 1'b0) begin errors++; $display("[TB] FAIL tunc_reset_no: got %b expected 0", tmr_bus.reset_no); end
    checks++; if (tmr_bus.recovering_o !== 1'b1) begin errors++; $display("[TB] FAIL tunc_recovering: got %b expected 1", tmr_bus.recovering_o); end
    tmr_drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick(); tick(); tick(); tick();
    checks++; if (tmr_bus.recover_o !== 1'b1) begin errors++; $display("[TB] FAIL tunc_recover: got %b expected 1", tmr_bus.recover_o); end
    tmr_bus.done_i = 1'b1;
    tick();
    tmr_bus.done_i = 1'b0;
    checks++; if (tmr_bus.recover_o !== 1'b0) begin errors++; $display("[TB] FAIL tunc_done: got %b expected 0", tmr_bus.recover_o); end
    tmr_bus.rec_req_i = 1'b1; tmr_bus.rec_addr_i = 6'h09;
    tick();
    checks++; if (tmr_bus.rec_rdata_o !== 32'h77) begin errors++; $display("[TB] FAIL tunc_r9: got %h expected 00000077", tmr_bus.rec_rdata_o); end
    tmr_bus.rec_addr_i = 6'h20;
    tick();
    checks++; if (tmr_bus.rec_rdata_o !== 32'h204) begin errors++; $display("[TB] FAIL tunc_ckpt: got %h expected 00000204", tmr_bus.rec_rdata_o); end
    tmr_bus.rec_req_i = 1'b0;
  endtask

  task automatic test_fatal();
    dmr_drive(1'b1, 5'd1, 32'h11, 32'h11, 32'h300);
    tick();
    for (int n = 1; n <= 3; n++) begin
      dmr_drive(1'b1, 5'd1, 32'hF0, 32'h0F, 32'h600);
      tick();
      checks++; if (dmr_bus.reset_no !== 1'b0) begin errors++; $display("[TB] FAIL fatal_retry%0d_reset_no: got %b expected 0", n, dmr_bus.reset_no); end
      checks++; if (dmr_bus.fatal_o !== 1'b0) begin errors++; $display("[TB] FAIL fatal_retry%0d_fatal: got %b expected 0", n, dmr_bus.fatal_o); end
      dmr_drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
      tick(); tick(); tick(); tick();
      checks++; if (dmr_bus.recover_o !== 1'b1) begin errors++; $display("[TB] FAIL fatal_retry%0d_recover: got %b expected 1", n, dmr_bus.recover_o); end
      dmr_bus.done_i = 1'b1;
      tick();
      dmr_bus.done_i = 1'b0;
    end
    dmr_drive(1'b1, 5'd1, 32'hF0, 32'h0F, 32'h600);
    tick();
    checks++; if (dmr_bus.fatal_o !== 1'b1) begin errors++; $display("[TB] FAIL fatal_set: got %b expected 1", dmr_bus.fatal_o); end
    checks++; if (dmr_bus.reset_no !== 1'b0) begin errors++; $display("[TB] FAIL fatal_reset_no: got %b expected 0", dmr_bus.reset_no); end
    checks++; if (dmr_bus.recovering_o !== 1'b0) begin errors++; $display("[TB] FAIL fatal_recovering: got %b expected 0", dmr_bus.recovering_o); end
    checks++; if (dmr_bus.err_count_o !== 8'd5) begin errors++; $display("[TB] FAIL fatal_count: got %0d expected 5", dmr_bus.err_count_o); end
    // done_i and clean writes have no effect while fatal.
    dmr_drive(1'b1, 5'd1, 32'h99, 32'h99, 32'h700);
    dmr_bus.done_i = 1'b1;
    tick(); tick();
    dmr_bus.done_i = 1'b0;
    dmr_drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    checks++; if (dmr_bus.fatal_o !== 1'b1) begin errors++; $display("[TB] FAIL fatal_sticky: got %b expected 1", dmr_bus.fatal_o); end
    checks++; if (dmr_bus.reset_no !== 1'b0) begin errors++; $display("[TB] FAIL fatal_stuck: got %b expected 0", dmr_bus.reset_no); end
    checks++; if (dmr_bus.recover_o !== 1'b0) begin errors++; $display("[TB] FAIL fatal_recover: got %b expected 0", dmr_bus.recover_o); end
    dmr_bus.rec_req_i = 1'b1; dmr_bus.rec_addr_i = 6'h01;
    tick();
    checks++; if (dmr_bus.rec_rdata_o !== 32'h11) begin errors++; $display("[TB] FAIL fatal_r1: got %h expected 00000011", dmr_bus.rec_rdata_o); end
    dmr_bus.rec_req_i = 1'b0;
  endtask

  task automatic test_reset_during_recovery();
    rst_n = 1'b0;
    #1;
    checks++; if (dmr_bus.fatal_o !== 1'b0) begin errors++; $display("[TB] FAIL rdr_fatal_clear: got %b expected 0", dmr_bus.fatal_o); end
    tick();
    rst_n = 1'b1;
    tick();
    dmr_drive(1'b1, 5'd1, 32'h3, 32'h4, 32'h900);
    tick();
    checks++; if (dmr_bus.recovering_o !== 1'b1) begin errors++; $display("[TB] FAIL rdr_enter: got %b expected 1", dmr_bus.recovering_o); end
    dmr_drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    #3 rst_n = 1'b0;
    #1;
    checks++; if (dmr_bus.recovering_o !== 1'b0) begin errors++; $display("[TB] FAIL rdr_recovering: got %b expected 0", dmr_bus.recovering_o); end
    checks++; if (dmr_bus.reset_no !== 1'b0) begin errors++; $display("[TB] FAIL rdr_reset_no: got %b expected 0", dmr_bus.reset_no); end
    checks++; if (dmr_bus.err_count_o !== 8'd0) begin errors++; $display("[TB] FAIL rdr_count: got %0d expected 0", dmr_bus.err_count_o); end
    checks++; if (dmr_bus.error_o !== 1'b0) begin errors++; $display("[TB] FAIL rdr_error: got %b expected 0", dmr_bus.error_o); end
    checks++; if (tmr_bus.faulty_core_o !== 3'b000) begin errors++; $display("[TB] FAIL rdr_tmr_faulty: got %b expected 000", tmr_bus.faulty_core_o); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    checks++; if (dmr_bus.reset_no !== 1'b1) begin errors++; $display("[TB] FAIL rdr_release: got %b expected 1", dmr_bus.reset_no); end
    dmr_bus.rec_req_i = 1'b1; dmr_bus.rec_addr_i = 6'h01;
    tmr_bus.rec_req_i = 1'b1; tmr_bus.rec_addr_i = 6'h07;
    tick();
    checks++; if (dmr_bus.rec_rdata_o !== 32'h11) begin errors++; $display("[TB] FAIL rdr_r1: got %h expected 00000011", dmr_bus.rec_rdata_o); end
    checks++; if (tmr_bus.rec_rdata_o !== 32'h0F) begin errors++; $display("[TB] FAIL rdr_tmr_r7: got %h expected 0000000f", tmr_bus.rec_rdata_o); end
    dmr_bus.rec_addr_i = 6'h20;
    tick();
    checks++; if (dmr_bus.rec_rdata_o !== 32'h300) begin errors++; $display("[TB] FAIL rdr_ckpt: got %h expected 00000300", dmr_bus.rec_rdata_o); end
    dmr_bus.rec_req_i = 1'b0;
    tmr_bus.rec_req_i = 1'b0;
  endtask

  task automatic test_saturation();
    tmr_drive(1'b1, 5'd2, 32'h5, 32'h6, 32'h5, 32'h800);
    for (int i = 0; i < 254; i++) tick();
    checks++; if (tmr_bus.err_count_o !== 8'd254) begin errors++; $display("[TB] FAIL sat_254: got %0d expected 254", tmr_bus.err_count_o); end
    tick();
    checks++; if (tmr_bus.err_count_o !== 8'd255) begin errors++; $display("[TB] FAIL sat_255: got %0d expected 255", tmr_bus.err_count_o); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (tmr_bus.err_count_o !== 8'd255) begin errors++; $display("[TB] FAIL sat_hold: got %0d expected 255", tmr_bus.err_count_o); end
    checks++; if (tmr_bus.reset_no !== 1'b1) begin errors++; $display("[TB] FAIL sat_reset_no: got %b expected 1", tmr_bus.reset_no); end
    tmr_drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_dmr_commit();
    test_same_cycle_read();
    test_bypass();
    test_dmr_fault();
    test_tmr_correct();
    test_tmr_uncorrectable();
    test_fatal();
    test_reset_during_recovery();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ftm_nmr.md
# ftm_nmr

Parametrised N-modular fault-tolerance manager for 2 or 3 lockstep cores. It compares or votes the per-core register-file writebacks and commits clean results into a protected shadow register file. It checkpoints the committed PC and runs a reset/recover sequence with a bounded retry count. It sits between the redundant cores and the recovery firmware path, which reads the shadow state back through a req/gnt/rvalid port.

## Interface
- NUM_CORES, 2 — 2 = DMR (detect only), 3 = TMR (majority vote).
- ADDR_WIDTH, 5 — register index width; shadow RF depth 2^ADDR_WIDTH.
- DATA_WIDTH, 32 — register/PC width.
- RESET_CYCLES, 4 — cycles reset_no is held low per recovery (≥1).
- MAX_RETRIES, 3 — consecutive failed recoveries tolerated before fatal (≥1).
- RESYNC_ON_CORRECT, 1 — TMR only: 1 = a corrected fault also triggers recovery to resync the faulty core.
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- enable_i  in  1  0 = bypass: core 0 writes commit unchecked; no errors raised.
- valid_i  in  NUM_CORES  per-core valid retired instruction.
- we_i  in  NUM_CORES  per-core RF write enable.
- addr_i  in  NUM_CORES*ADDR_WIDTH  per-core write address, core k at slice k.
- data_i  in  NUM_CORES*DATA_WIDTH  per-core write data.
- pc_i  in  NUM_CORES*DATA_WIDTH  per-core PC of the retiring instruction.
- rec_req_i  in  1  shadow read request.
- rec_addr_i  in  ADDR_WIDTH+1  MSB=0: RF index; MSB=1: checkpoint PC.
- rec_gnt_o  out  1  grant, = rec_req_i (combinational).
- rec_rvalid_o  out  1  read data valid.
- rec_rdata_o  out  DATA_WIDTH  read data.
- done_i  in  1  recovery firmware finished.
- reset_no  out  1  active-low core reset.
- recover_o  out  1  cores must execute the recovery routine.
- recovering_o  out  1  high in RESET and RECOVER states.
- error_o  out  1  one-cycle pulse per detected fault.
- fatal_o  out  1  sticky unrecoverable fault.
- faulty_core_o  out  NUM_CORES  sticky per-core blame bits (TMR only; 0 in DMR).
- err_count_o  out  8  saturating count of detected faults (corrected + uncorrected).

## Operation
- Compare tuple per core: {valid, we, addr, data, pc}. Checking is active only when enable_i=1, state=RUN, and any valid_i=1.
- DMR: any tuple difference = uncorrectable fault.
- TMR: bitwise majority per field gives the voted tuple.
  - A core that differs from the vote is blamed: its faulty_core_o bit sets and stays set.
  - Exactly one blamed core = corrected fault. The voted write commits.
  - Two or more blamed cores (no two cores agree) = uncorrectable fault.
- Commit: shadow RF[addr] ← data when the voted/agreed valid&we=1 and there is no uncorrectable fault. The checkpoint PC ← voted pc under the same condition, regardless of we.
- On an uncorrectable fault the write and the PC update are discarded. The checkpoint stays frozen.
- FSM states:
  - RUN→RESET on an uncorrectable fault, or on a corrected fault when RESYNC_ON_CORRECT=1.
  - RESET: reset_no=0 for RESET_CYCLES cycles, then →RECOVER.
  - RECOVER: recover_o=1 until done_i=1, then →RUN.
  - FATAL: absorbing; reset_no=0, recover_o=0, fatal_o=1. Exit only via rst_ni.
- Retry counter:
  - Increments on each RUN→RESET transition.
  - Clears on any clean commit in RUN.
  - A fault raised with retry count = MAX_RETRIES goes →FATAL instead of RESET.
- Faults, done_i and valid_i outside their qualifying state are ignored.
- The shadow RF and checkpoint are not cleared by rst_ni (data only). All control state is reset.

## Timing
- Reset values: state=RUN, reset_no=0, recover_o=0, recovering_o=0, error_o=0, fatal_o=0, faulty_core_o=0, err_count_o=0, retry=0, rec_rvalid_o=0.
- reset_no rises on the first rising edge after rst_ni deasserts.
- Detection is combinational. Commit happens on the same edge (zero latency).
- error_o, err_count_o and faulty_core_o update on the edge after the fault cycle.
- Outputs are registered. reset_no goes low on the edge after the fault cycle and stays low exactly RESET_CYCLES cycles.
- recover_o and recovering_o follow the FSM state.
- done_i sampled in RECOVER: recover_o=0 and state=RUN on the next edge. Faults are checked again starting that RUN cycle.
- Read port:
  - rec_rvalid_o and rec_rdata_o are registered one cycle after an accepted rec_req_i. Back-to-back reads are allowed, one per cycle, in all states.
  - A read and a commit to the same address in the same cycle returns the old value.
- err_count_o saturates at 255.

## Test plan
- DMR, enable=1, both cores write r5=0xDEADBEEF, pc=0x100 → RF[5]=0xDEADBEEF; read rec_addr=5 gives 0xDEADBEEF one cycle later; read rec_addr=0x20 gives 0x100; error_o never pulses.
- DMR, data differs (0x1 vs 0x2) on r3 → r3 unchanged; error_o pulses once; reset_no low for 4 cycles; recover_o high until done_i; back in RUN the cycle after done_i.
- TMR, RESYNC_ON_CORRECT=0, core 1 data=0xFF, others 0x0F to r7 → RF[7]=0x0F; faulty_core_o=3'b010; err_count_o=1; reset_no stays 1.
- TMR, all three data differ → treated as uncorrectable; faulty_core_o=3'b111; recovery sequence starts.
- DMR, MAX_RETRIES=3, fault immediately after each recovery → 3 recoveries, then the 4th fault gives fatal_o=1, reset_no stuck 0; done_i has no effect until rst_ni.
- Assert rst_ni low during RESET → all control outputs at reset values immediately; shadow RF contents preserved.
